es_fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core. It drives a synchronous-read instruction memory, tracks the PC, and presents instruction word, PC and PC+4 to the decode stage, where the immediate decoder and register file consume them. It absorbs decode-stage stalls with a one-entry skid buffer and accepts branch/jump redirects from EX. It optionally predicts JAL targets early.

---
 rtl/es_fetch_stage_if.sv | 33 +++
 rtl/es_fetch_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/es_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode-side control
// (stall/flush/redirect) and the IF/ID outputs toward decode.
interface es_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic [XLEN-1:0] id_instruction;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic            id_pred_taken;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    input  stall, flush, redirect_pc,
    output id_valid, id_instruction,
    output id_pc, id_pc_plus4, id_pred_taken
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    output stall, flush, redirect_pc,
    input  id_valid, id_instruction,
    input  id_pc, id_pc_plus4, id_pred_taken
  );
endinterface

// File: rtl/es_fetch_stage.sv
// RV32I fetch stage + IF/ID register with one-entry skid buffer.
// Optional early JAL redirect: define ES_FETCH_JAL_PREDICT_EN.
module es_fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input logic              clk,
  input logic              reset,
  es_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {ISSUE, RUN, HOLD} state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_pc, req_pc_n;
  logic            skid_valid, skid_valid_n;
  logic [XLEN-1:0] skid_instr, skid_instr_n;
  logic [XLEN-1:0] skid_pc, skid_pc_n;
  logic            id_valid, id_valid_n;
  logic [XLEN-1:0] id_instr, id_instr_n;
  logic [XLEN-1:0] id_pc, id_pc_n;
  logic [XLEN-1:0] id_p4, id_p4_n;
  logic            id_pred, id_pred_n;
  logic            en;
  logic            bubble;
  logic            is_jal;
  logic [XLEN-1:0] jal_imm;

`ifdef ES_FETCH_JAL_PREDICT_EN
  assign is_jal  = bus.imem_rdata[6:0] == 7'b1101111;
  assign jal_imm = XLEN'($signed({bus.imem_rdata[31],
                                  bus.imem_rdata[19:12],
                                  bus.imem_rdata[20],
                                  bus.imem_rdata[30:21],
                                  1'b0}));
`else
  assign is_jal  = 1'b0;
  assign jal_imm = '0;
`endif

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_pc_n     = req_pc;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    id_valid_n   = id_valid;
    id_instr_n   = id_instr;
    id_pc_n      = id_pc;
    id_p4_n      = id_p4;
    id_pred_n    = id_pred;
    en           = 1'b0;
    bubble       = 1'b0;
    if (bus.flush) begin
      pc_n         = bus.redirect_pc & ~XLEN'(3);
      skid_valid_n = 1'b0;
      bubble       = 1'b1;
      state_n      = ISSUE;
    end else begin
      unique case (state)
        ISSUE: begin
          en       = 1'b1;
          req_pc_n = pc;
          pc_n     = pc + FOUR;
          state_n  = RUN;
          bubble   = !bus.stall;
        end
        RUN: begin
          if (!bus.stall) begin
            id_valid_n = 1'b1;
            id_instr_n = bus.imem_rdata;
            id_pc_n    = req_pc;
            id_p4_n    = req_pc + FOUR;
            id_pred_n  = is_jal;
            // predicted JAL: drop the sequential fetch, refetch at target
            if (is_jal) begin
              pc_n    = req_pc + jal_imm;
              state_n = ISSUE;
            end else begin
              en       = 1'b1;
              req_pc_n = pc;
              pc_n     = pc + FOUR;
            end
          end else begin
            skid_valid_n = 1'b1;
            skid_instr_n = bus.imem_rdata;
            skid_pc_n    = req_pc;
            state_n      = HOLD;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            id_valid_n   = skid_valid;
            id_instr_n   = skid_instr;
            id_pc_n      = skid_pc;
            id_p4_n      = skid_pc + FOUR;
            id_pred_n    = 1'b0;
            skid_valid_n = 1'b0;
            en           = 1'b1;
            req_pc_n     = pc;
            pc_n         = pc + FOUR;
            state_n      = RUN;
          end
        end
        default: state_n = ISSUE;
      endcase
    end
    if (bubble) begin
      id_valid_n = 1'b0;
      id_instr_n = NOP_INSTR;
      id_pc_n    = '0;
      id_p4_n    = '0;
      id_pred_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ISSUE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      id_valid   <= 1'b0;
      id_instr   <= NOP_INSTR;
      id_pc      <= '0;
      id_p4      <= '0;
      id_pred    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_pc     <= req_pc_n;
      skid_valid <= skid_valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      id_valid   <= id_valid_n;
      id_instr   <= id_instr_n;
      id_pc      <= id_pc_n;
      id_p4      <= id_p4_n;
      id_pred    <= id_pred_n;
    end
  end

  assign bus.imem_en        = en & ~reset;
  assign bus.imem_addr      = pc;
  assign bus.id_valid       = id_valid;
  assign bus.id_instruction = id_instr;
  assign bus.id_pc          = id_pc;
  assign bus.id_pc_plus4    = id_p4;
  assign bus.id_pred_taken  = id_pred;

endmodule
